secded_stream_decoder: RTL and testbench

SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

---
 rtl/secded_pkg.sv | 45 ++++
 rtl/secded_syndrome.sv | 25 ++
 rtl/secded_stream_decoder.sv | 168 ++++++++++++++++
 tb/tb_secded_stream_decoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared SECDED definitions: status codes, parity-count and position helpers.
// Used by the stream decoder and by the matching encoder.
package secded_pkg;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_SINGLE = 2'b01;
  localparam logic [1:0] ST_DOUBLE = 2'b10;
  localparam logic [1:0] ST_PARITY = 2'b11;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int parity_bits(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Hamming position (1-based) that carries data bit idx.
  function automatic int data_pos(input int idx);
    int pos;
    int seen;
    pos  = 0;
    seen = -1;
    while (seen < idx) begin
      pos++;
      if (!is_pow2(pos)) seen++;
    end
    return pos;
  endfunction

  // Positions (bit i = position i+1) that contribute to syndrome bit k.
  function automatic logic [63:0] syn_mask(input int k, input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n; i++) begin
      if ((((i + 1) >> k) & 1) != 0) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall-parity mismatch of one codeword.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int P      = parity_bits(DATA_W),
  localparam int N      = DATA_W + P,
  localparam int CW     = N + 1
) (
  input  logic [CW-1:0] code,
  output logic [P-1:0]  syndrome,
  output logic          overall
);

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_syn
      localparam logic [63:0] MASK = syn_mask(gi, N);
      assign syndrome[gi] = ^(code[N-1:0] & MASK[N-1:0]);
    end
  endgenerate

  assign overall = ^code;

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage streaming SECDED decoder with valid/ready handshakes, optional
// single-error correction and saturating error counters.
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 8,
  localparam int P      = parity_bits(DATA_W),
  localparam int N      = DATA_W + P,
  localparam int CW     = N + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_code,
  input  logic              cfg_correct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic [P-1:0]      out_err_pos,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  logic [P-1:0]      in_syn;
  logic              in_ovr;
  logic [DATA_W-1:0] in_raw;
  logic [DATA_W-1:0] fix_mask;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
  logic              s1_ovr_q, s1_ovr_d;
  logic              s1_cfg_q, s1_cfg_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_status_q, out_status_d;
  logic [P-1:0]      out_pos_q, out_pos_d;

  logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

  logic              s2_advance;
  logic [1:0]        s1_status;
  logic [DATA_W-1:0] s1_corr;
  logic              out_fire;

  secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code     (in_code),
    .syndrome (in_syn),
    .overall  (in_ovr)
  );

  // Only payload positions are kept past stage 0; syndrome and O carry the rest.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam int POS = data_pos(gi);
      assign in_raw[gi]   = in_code[POS-1];
      assign fix_mask[gi] = (s1_syn_q == P'(POS));
    end
  endgenerate

  assign s2_advance = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;
  assign out_fire   = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    s1_ovr_d   = s1_ovr_q;
    s1_cfg_d   = s1_cfg_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_raw;
        s1_syn_d  = in_syn;
        s1_ovr_d  = in_ovr;
        s1_cfg_d  = cfg_correct;
      end
    end
  end

  always_comb begin
    s1_status = ST_CLEAN;
    if (s1_syn_q == '0) begin
      s1_status = s1_ovr_q ? ST_PARITY : ST_CLEAN;
    end else if (s1_ovr_q && (s1_syn_q <= P'(N))) begin
      s1_status = ST_SINGLE;
    end else begin
      s1_status = ST_DOUBLE;
    end
    s1_corr = s1_data_q;
    // A flipped parity position leaves fix_mask all-zero, so data is untouched.
    if (s1_status == ST_SINGLE && s1_cfg_q) s1_corr = s1_data_q ^ fix_mask;
  end

  // The syndrome is zero exactly for statuses 00 and 11, so it is the position.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_status_d = out_status_q;
    out_pos_d    = out_pos_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = s1_corr;
        out_status_d = s1_status;
        out_pos_d    = s1_syn_q;
      end
    end
  end

  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (clr_cnt) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (out_fire) begin
      if ((out_status_q == ST_SINGLE || out_status_q == ST_PARITY) && !(&cnt_single_q))
        cnt_single_d = cnt_single_q + CNT_W'(1);
      if (out_status_q == ST_DOUBLE && !(&cnt_double_q))
        cnt_double_d = cnt_double_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_ovr_q     <= 1'b0;
      s1_cfg_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= ST_CLEAN;
      out_pos_q    <= '0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      s1_ovr_q     <= s1_ovr_d;
      s1_cfg_q     <= s1_cfg_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
      out_pos_q    <= out_pos_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_status  = out_status_q;
  assign out_err_pos = out_pos_q;
  assign cnt_single  = cnt_single_q;
  assign cnt_double  = cnt_double_q;

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Scoreboard bench for secded_stream_decoder (DATA_W=4, CNT_W=8): directed
// vectors, randomized error injection, saturation, clear and mid-run reset.
module tb_secded_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_code = '0;
  logic       cfg_correct = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_status;
  logic [2:0] out_err_pos;
  logic       clr_cnt = 1'b0;
  logic [7:0] cnt_single;
  logic [7:0] cnt_double;

  secded_stream_decoder #(.DATA_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .cfg_correct (cfg_correct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_status  (out_status),
    .out_err_pos (out_err_pos),
    .clr_cnt     (clr_cnt),
    .cnt_single  (cnt_single),
    .cnt_double  (cnt_double)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [1:0] status;
    logic [2:0] pos;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_single = 0;
  int   exp_double = 0;
  int   delivered = 0;
  bit   rand_ready = 1'b0;
  bit   stall_prev = 1'b0;
  logic [8:0] prev_out = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference decode: syndrome as XOR of the indices of the set positions.
  function automatic exp_t model(input logic [7:0] code, input bit cfg);
    exp_t r;
    int s, st, j;
    bit o;
    logic [7:0] w;
    s = 0;
    j = 0;
    o = ^code;
    for (int pos = 1; pos <= 7; pos++) if (code[pos-1]) s = s ^ pos;
    if (s == 0) st = o ? 3 : 0;
    else if (!o) st = 2;
    else if (s > 7) st = 2;
    else st = 1;
    w = code;
    if (st == 1 && cfg) w[s-1] = ~w[s-1];
    r.data = '0;
    for (int pos = 1; pos <= 7; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        r.data[j] = w[pos-1];
        j++;
      end
    end
    r.status = 2'(st);
    r.pos    = (st == 1 || st == 2) ? 3'(s) : 3'd0;
    r.lat    = -1;
    return r;
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    int s, j;
    c = '0;
    j = 0;
    s = 0;
    for (int pos = 1; pos <= 7; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
        if (c[pos-1]) s = s ^ pos;
      end
    end
    for (int k = 0; k < 3; k++) c[(1 << k) - 1] = s[k];
    c[7] = ^c[6:0];
    return c;
  endfunction

  task automatic send(input logic [7:0] code, input bit cfg, input exp_t e, input bit timed);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid    = 1'b1;
    in_code     = code;
    cfg_correct = cfg;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        bound_fail("in_ready_wait");
        break;
      end
    end
    e.lat = timed ? cyc + 2 : -1;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) bound_fail("drain");
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expectations on each output handshake, tracks counters.
  always @(negedge clk) begin
    exp_t e;
    bit   popped;
    popped = 1'b0;
    if (!rst_n) begin
      exp_single = 0;
      exp_double = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_payload", 32'({out_data, out_status, out_err_pos}), 32'(prev_out));
      end
      check("cnt_single", 32'(cnt_single), 32'(exp_single));
      check("cnt_double", 32'(cnt_double), 32'(exp_double));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          bound_fail("unexpected_output");
        end else begin
          e = sb.pop_front();
          popped = 1'b1;
          delivered++;
          $display("OUT #%0d data=%b status=%b pos=%0d", delivered, out_data, out_status, out_err_pos);
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_status", 32'(out_status), 32'(e.status));
          check("out_err_pos", 32'(out_err_pos), 32'(e.pos));
          if (e.lat >= 0) check("latency", 32'(cyc), 32'(e.lat));
        end
      end
      if (clr_cnt) begin
        exp_single = 0;
        exp_double = 0;
      end else if (popped) begin
        if ((e.status == 2'b01 || e.status == 2'b11) && exp_single < 255) exp_single++;
        if (e.status == 2'b10 && exp_double < 255) exp_double++;
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_data, out_status, out_err_pos};
    end
  end

  initial begin
    logic [7:0] code;
    logic [3:0] d;
    int kind, b1, b2, n;
    bit cfg;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_status", 32'(out_status), 32'd0);
    check("rst_out_err_pos", 32'(out_err_pos), 32'd0);
    check("rst_cnt_single", 32'(cnt_single), 32'd0);
    check("rst_cnt_double", 32'(cnt_double), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    send(8'h55, 1'b1, exp_t'{4'b1011, 2'b00, 3'd0, -1}, 1'b1);
    send(8'h45, 1'b1, exp_t'{4'b1011, 2'b01, 3'd5, -1}, 1'b1);
    send(8'h44, 1'b1, exp_t'{4'b1001, 2'b10, 3'd4, -1}, 1'b1);
    send(8'hD5, 1'b1, exp_t'{4'b1011, 2'b11, 3'd0, -1}, 1'b1);
    send(8'h45, 1'b0, exp_t'{4'b1001, 2'b01, 3'd5, -1}, 1'b1);
    idle();
    drain();
    check("dir_cnt_single", 32'(cnt_single), 32'd3);
    check("dir_cnt_double", 32'(cnt_double), 32'd1);

    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      d    = 4'($urandom);
      code = encode(d);
      kind = $urandom_range(0, 3);
      b1   = $urandom_range(0, 7);
      b2   = (b1 + $urandom_range(1, 7)) % 8;
      if (kind == 1) code[b1] = ~code[b1];
      if (kind == 2) begin
        code[b1] = ~code[b1];
        code[b2] = ~code[b2];
      end
      cfg = 1'($urandom_range(0, 1));
      send(code, cfg, model(code, cfg), 1'b0);
    end

    for (int i = 0; i < 300; i++) send(8'h45, 1'b1, exp_t'{4'b1011, 2'b01, 3'd5, -1}, 1'b0);
    idle();
    drain();
    check("delivered_count", 32'(delivered), 32'd505);
    check("sat_cnt_single", 32'(cnt_single), 32'd255);

    rand_ready = 1'b0;
    out_ready  = 1'b1;
    send(8'h45, 1'b1, exp_t'{4'b1011, 2'b01, 3'd5, -1}, 1'b0);
    idle();
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) bound_fail("clr_wait");
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check("clr_cnt_single", 32'(cnt_single), 32'd0);
    check("clr_cnt_double", 32'(cnt_double), 32'd0);
    drain();

    out_ready = 1'b0;
    send(8'h55, 1'b1, exp_t'{4'b1011, 2'b00, 3'd0, -1}, 1'b0);
    send(8'h44, 1'b1, exp_t'{4'b1001, 2'b10, 3'd4, -1}, 1'b0);
    idle();
    @(posedge clk);
    #1;
    check("stalled_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_cnt_double", 32'(cnt_double), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_no_output", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(8'hD5, 1'b1, exp_t'{4'b1011, 2'b11, 3'd0, -1}, 1'b1);
    idle();
    drain();
    check("post_rst_cnt_single", 32'(cnt_single), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
